stroke_packet_rx: RTL and testbench
===================================

// Module: stroke_packet_rx
// PURPOSE
//  Serial receiver for the inter-FPGA stroke link. Sits directly downstream of the
//  pmodb IBUFDS + synchronizer and upstream of the comm_x/y/color/sw capture
//  registers feeding frame_buffer port 2.
//  Recovers 26-bit stroke packets {x[9:0], y[8:0], color[3:0], width[2:0]} from an
//  oversampled UART-style bit stream. Checks parity and framing, and reports link errors.
// PARAMETERS
//  BIT_CYCLES     100  clk_in cycles per bit (1 Mbps at 100 MHz); even, >= 4
//  DATA_WIDTH     26   payload bits per packet
//  ERR_CNT_WIDTH  8    width of saturating error counter
// PORTS
//  clk_in          in   1           system clock (buffered 100 MHz)
//  rst_n_in        in   1           asynchronous, active-low reset
//  data_in         in   1           synchronized serial line; idle high
//  code_out        out  DATA_WIDTH  last good payload; holds until next good packet
//  new_code_out    out  1           1-cycle pulse: code_out updated this cycle
//  parity_err_out  out  1           1-cycle pulse: packet dropped, parity bad
//  frame_err_out   out  1           1-cycle pulse: packet dropped, stop bit low
//  err_count_out   out  ERR_CNT_WIDTH  saturating count of parity + frame errors
//  busy_out        out  1           high in any state other than IDLE
// BEHAVIOUR
//  Frame format: start(0), 26 data bits MSB first, even-parity bit, stop(1).
//  Parity rule: XOR of the 26 data bits and the parity bit must be 0.
//  Reset (async assert, sync release): all outputs 0, state IDLE, counters 0, prev_q=1.
//  States:
//   IDLE   wait for a falling edge (prev_q==1 && data_in==0); clear cyc_cnt; go to START.
//          A line stuck low never triggers.
//   START  at cyc_cnt==BIT_CYCLES/2-1, sample the line:
//          1 -> back to IDLE (glitch; no error flagged);
//          0 -> clear cyc_cnt and bit_idx; go to DATA.
//   DATA   sample at cyc_cnt==BIT_CYCLES-1 (mid-bit); shift into shreg from the LSB side;
//          after sample 26 (bit_idx==DATA_WIDTH-1), go to PARITY.
//   PARITY sample at mid-bit; latch par_ok; go to STOP.
//   STOP   sample at mid-bit:
//          1 && par_ok  -> code_out<=shreg; pulse new_code_out; go to IDLE;
//          1 && !par_ok -> pulse parity_err_out; go to IDLE;
//          0            -> pulse frame_err_out; go to BREAK
//                          (a simultaneous parity fault reports as frame error only).
//   BREAK  wait for data_in==1; then go to IDLE. Prevents resync inside garbage.
//  Latency: new_code_out rises BIT_CYCLES/2 + 28*BIT_CYCLES + 1 cycles after the
//   cycle the falling edge is detected (2851 at defaults).
//  Outputs are registered. Pulses are exactly one cycle wide.
//   code_out is never partially updated.
//  err_count_out increments by 1 per error pulse and saturates at all-ones (no wrap).
//  Back-to-back frames: a start edge in the cycle after the stop sample must be accepted.
//  The stop bit may be as short as BIT_CYCLES/2.
//  Reset mid-frame: discard shreg; no pulse is emitted.
// STRUCTURE
//  comm_pkg: DATA_WIDTH, field offsets (X_MSB=25 X_LSB=16, Y 15:7, COLOR 6:3, SW 2:0),
//   rx_state_t enum {IDLE,START,DATA,PARITY,STOP,BREAK}.
//   The same package is shared with diff_tx.
//  Sub-module: rx_bit_timer
//   - cyc_cnt with restart input;
//   - half-period / full-period tick outputs.
//  The FSM and shift register stay in this module.
// TESTING (bench drives data_in at BIT_CYCLES=100)
//  1 Send x=320 y=180 color=5 width=2 (payload 26'h1405A2A, parity 1)
//    -> single new_code_out pulse 2851 cycles after edge; code_out=26'h1405A2A.
//  2 Same packet with parity 0 -> parity_err_out pulse; code_out unchanged;
//    err_count_out=1.
//  3 Stop bit driven 0 -> frame_err_out pulse.
//    Line held low 500 cycles, then high; next valid packet is received.
//  4 30-cycle low glitch on idle line -> no pulses; busy_out returns 0 by cycle 50.
//  5 Two packets back-to-back, stop bit 50 cycles -> two new_code_out pulses,
//    both payloads correct.
//  6 rst_n_in low for 3 cycles during bit 12 -> all outputs 0 immediately.
//    Following packet decodes correctly. Also: 300 bad packets -> err_count_out=255.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared definitions for the inter-FPGA stroke link (receiver and transmitter).
// Packet layout is {x[9:0], y[8:0], color[3:0], width[2:0]}, sent MSB first.
package comm_pkg;
    localparam int DATA_WIDTH = 26;

    localparam int X_MSB     = 25;
    localparam int X_LSB     = 16;
    localparam int Y_MSB     = 15;
    localparam int Y_LSB     = 7;
    localparam int COLOR_MSB = 6;
    localparam int COLOR_LSB = 3;
    localparam int SW_MSB    = 2;
    localparam int SW_LSB    = 0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;
endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer for the stroke receiver: free-running cycle counter that the
// FSM restarts at each bit boundary, with half-period and full-period ticks.
module rx_bit_timer #(
    parameter int BIT_CYCLES = 100
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic restart,
    output logic half_tick,
    output logic full_tick
);
    // One extra count of headroom so the counter can sit one past the last tick.
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cyc_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cyc_cnt <= '0;
        end else if (restart) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
        end
    end

    assign half_tick = (cyc_cnt == HALF_LAST);
    assign full_tick = (cyc_cnt == FULL_LAST);
endmodule

// File: rtl/stroke_packet_rx.sv
// Stroke-link serial receiver: recovers stroke packets from an oversampled
// start/data/parity/stop stream and flags parity and framing faults.
module stroke_packet_rx #(
    parameter int BIT_CYCLES    = 100,
    parameter int DATA_WIDTH    = 26,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     data_in,
    output logic [DATA_WIDTH-1:0]    code_out,
    output logic                     new_code_out,
    output logic                     parity_err_out,
    output logic                     frame_err_out,
    output logic [ERR_CNT_WIDTH-1:0] err_count_out,
    output logic                     busy_out
);
    import comm_pkg::*;

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    rx_state_t             state;
    logic                  prev_q;
    logic [DATA_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]      bit_idx;
    logic                  par_ok;
    logic                  half_tick;
    logic                  full_tick;
    logic                  restart;

    // The timer is held at zero while idle, so the start-bit half period is
    // measured from the cycle the falling edge is seen.
    always_comb begin
        restart = (state == IDLE) || (state == BREAK)
               || ((state == START) && half_tick)
               || (((state == DATA) || (state == PARITY)) && full_tick);
    end

    rx_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .restart  (restart),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            prev_q         <= 1'b1;
            shreg          <= '0;
            bit_idx        <= '0;
            par_ok         <= 1'b0;
            code_out       <= '0;
            new_code_out   <= 1'b0;
            parity_err_out <= 1'b0;
            frame_err_out  <= 1'b0;
            err_count_out  <= '0;
            busy_out       <= 1'b0;
        end else begin
            prev_q         <= data_in;
            new_code_out   <= 1'b0;
            parity_err_out <= 1'b0;
            frame_err_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (prev_q && !data_in) begin
                        state    <= START;
                        busy_out <= 1'b1;
                    end
                end
                START: begin
                    if (half_tick) begin
                        if (data_in) begin
                            state    <= IDLE;
                            busy_out <= 1'b0;
                        end else begin
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (full_tick) begin
                        shreg   <= {shreg[DATA_WIDTH-2:0], data_in};
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_LAST) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (full_tick) begin
                        par_ok <= ~(^shreg ^ data_in);
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (full_tick) begin
                        if (data_in && par_ok) begin
                            code_out     <= shreg;
                            new_code_out <= 1'b1;
                            state        <= IDLE;
                            busy_out     <= 1'b0;
                        end else begin
                            // A bad stop bit masks any parity fault in the same frame.
                            if (data_in) begin
                                parity_err_out <= 1'b1;
                                state          <= IDLE;
                                busy_out       <= 1'b0;
                            end else begin
                                frame_err_out <= 1'b1;
                                state         <= BREAK;
                            end
                            if (err_count_out != '1) begin
                                err_count_out <= err_count_out + ERR_CNT_WIDTH'(1);
                            end
                        end
                    end
                end
                BREAK: begin
                    if (data_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stroke_packet_rx.sv
// Scoreboard bench for stroke_packet_rx: stimulus predicts each frame's outcome from
// the frame rules; a monitor checks every pulse. A fast second instance checks saturation.
module tb_stroke_packet_rx;
    localparam int BC  = 100;
    localparam int DW  = 26;
    localparam int LAT = BC / 2 + 28 * BC + 1;
    localparam int SBC = 4;

    typedef enum logic [1:0] {EV_CODE, EV_PAR, EV_FRM} ev_kind_t;
    typedef struct {
        ev_kind_t        kind;
        logic [DW-1:0]   code;
        int              err_count;
        int              cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          data_line;
    logic [DW-1:0] code;
    logic          new_code, par_err, frm_err, busy;
    logic [7:0]    err_count;

    logic          s_rst_n;
    logic          s_line;
    logic [DW-1:0] s_code;
    logic          s_new_code, s_par_err, s_frm_err, s_busy;
    logic [7:0]    s_err_count;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  s_err_pulses = 0;
    int  s_goods = 0;
    bit  sat_done = 0;
    ev_t exp_q[$];
    logic [DW-1:0] model_code = '0;
    int  model_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stroke_packet_rx #(.BIT_CYCLES(BC), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(8)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .data_in       (data_line),
        .code_out      (code),
        .new_code_out  (new_code),
        .parity_err_out(par_err),
        .frame_err_out (frm_err),
        .err_count_out (err_count),
        .busy_out      (busy)
    );

    stroke_packet_rx #(.BIT_CYCLES(SBC), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(8)) dut_fast (
        .clk_in        (clk),
        .rst_n_in      (s_rst_n),
        .data_in       (s_line),
        .code_out      (s_code),
        .new_code_out  (s_new_code),
        .parity_err_out(s_par_err),
        .frame_err_out (s_frm_err),
        .err_count_out (s_err_count),
        .busy_out      (s_busy)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Parity bit that makes the frame's data+parity ones count even.
    function automatic logic even_par(input logic [DW-1:0] p);
        return ($countones(p) % 2) == 1;
    endfunction

    // Called at a negedge; leaves the line at stop_val. reset_bit >= 0 aborts the
    // frame with a reset pulse in the middle of that data bit.
    task automatic send_frame(input logic [DW-1:0] payload, input logic par,
                              input logic stop_val, input int stop_len, input int reset_bit);
        logic [DW+1:0] bits;
        ev_t           e;
        bits = {1'b0, payload, par};
        if (reset_bit < 0) begin
            if (!stop_val) e.kind = EV_FRM;
            else if ((($countones(payload) + int'(par)) % 2) == 0) e.kind = EV_CODE;
            else e.kind = EV_PAR;
            if (e.kind == EV_CODE) model_code = payload;
            else if (model_err < 255) model_err++;
            e.code      = model_code;
            e.err_count = model_err;
            e.cyc       = cyc + LAT;
            exp_q.push_back(e);
        end
        for (int i = DW + 1; i >= 0; i--) begin
            data_line = bits[i];
            for (int c = 0; c < BC; c++) begin
                @(negedge clk);
                if (reset_bit >= 0 && (DW + 1 - i) == reset_bit + 1 && c == BC / 2) begin
                    rst_n     = 1'b0;
                    data_line = 1'b1;
                    #1;
                    check("rst_code_out", code, 0);
                    check("rst_pulses", {new_code, par_err, frm_err}, 0);
                    check("rst_err_count", err_count, 0);
                    check("rst_busy", busy, 0);
                    repeat (3) @(negedge clk);
                    rst_n      = 1'b1;
                    model_code = '0;
                    model_err  = 0;
                    return;
                end
            end
        end
        data_line = stop_val;
        repeat (stop_len) @(negedge clk);
    endtask

    task automatic s_send(input logic [DW-1:0] payload, input logic par, input logic stop_val);
        logic [DW+1:0] bits;
        bits = {1'b0, payload, par};
        for (int i = DW + 1; i >= 0; i--) begin
            s_line = bits[i];
            repeat (SBC) @(negedge clk);
        end
        s_line = stop_val;
        repeat (SBC) @(negedge clk);
        s_line = 1'b1;
    endtask

    // Scoreboard monitor: every pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        ev_t e;
        logic [2:0] want;
        if (rst_n && (new_code || par_err || frm_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {new_code, par_err, frm_err}, 0);
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    EV_CODE: want = 3'b100;
                    EV_PAR:  want = 3'b010;
                    default: want = 3'b001;
                endcase
                $display("[TB] cyc %0d: %s code=%h err=%0d", cyc, e.kind.name(), code, err_count);
                check("pulse_kind", {new_code, par_err, frm_err}, want);
                check("code_out", code, e.code);
                check("err_count", err_count, e.err_count);
                check("latency", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (s_par_err || s_frm_err) s_err_pulses <= s_err_pulses + 1;
        if (s_new_code) s_goods <= s_goods + 1;
    end

    initial begin : sat_proc
        logic [DW-1:0] p;
        s_rst_n = 1'b0;
        s_line  = 1'b1;
        idle(4);
        s_rst_n = 1'b1;
        idle(4);
        for (int k = 0; k < 300; k++) begin
            p = DW'($urandom);
            if (k % 10 == 9) s_send(p, even_par(p), 1'b0);
            else s_send(p, ~even_par(p), 1'b1);
            idle(3);
            if (k == 99) check("sat_count_100", s_err_count, 100);
        end
        check("sat_count_final", s_err_count, 255);
        check("sat_err_pulses", s_err_pulses, 300);
        check("sat_no_good", s_goods, 0);
        sat_done = 1;
    end

    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin : main_proc
        logic [DW-1:0] p, p2;
        logic          par;
        int            g, w;
        rst_n     = 1'b0;
        data_line = 1'b1;
        idle(3);
        check("reset_code_out", code, 0);
        check("reset_pulses", {new_code, par_err, frm_err}, 0);
        check("reset_err_count", err_count, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        idle(5);

        // x=320 y=180 color=5 width=2, good then bad parity.
        send_frame(26'h1405A2A, 1'b1, 1'b1, BC, -1);
        idle(20);
        send_frame(26'h1405A2A, 1'b0, 1'b1, BC, -1);
        idle(20);

        // Stop bit low, line held low, then a normal packet.
        p = DW'($urandom);
        send_frame(p, even_par(p), 1'b0, BC + 500, -1);
        data_line = 1'b1;
        idle(200);
        p = DW'($urandom);
        send_frame(p, even_par(p), 1'b1, BC, -1);
        idle(20);

        // Short low glitch on an idle line.
        data_line = 1'b0;
        g = cyc;
        idle(10);
        check("glitch_busy_high", busy, 1);
        idle(20);
        data_line = 1'b1;
        while (cyc < g + 55) @(negedge clk);
        check("glitch_busy_low", busy, 0);
        idle(20);

        // Back-to-back: next start edge right after the stop sample.
        p  = DW'($urandom);
        p2 = DW'($urandom);
        send_frame(p, even_par(p), 1'b1, BC / 2 + 1, -1);
        send_frame(p2, even_par(p2), 1'b1, BC, -1);
        idle(20);

        // Reset during data bit 12, then a clean packet.
        p = DW'($urandom);
        send_frame(p, even_par(p), 1'b1, BC, 12);
        idle(200);
        p = DW'($urandom);
        send_frame(p, even_par(p), 1'b1, BC, -1);
        idle(20);

        // Randomized frames: mostly good, some parity or framing faults.
        for (int r = 0; r < 6; r++) begin
            p   = DW'($urandom);
            par = even_par(p) ^ ($urandom_range(0, 3) == 0);
            w   = $urandom_range(1, 40);
            if ($urandom_range(0, 5) == 0) begin
                send_frame(p, par, 1'b0, BC + 50, -1);
                data_line = 1'b1;
            end else begin
                send_frame(p, par, 1'b1, BC, -1);
            end
            idle(w);
        end

        for (int t = 0; t < 4000 && exp_q.size() != 0; t++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        for (int t = 0; t < 60000 && !sat_done; t++) @(negedge clk);
        check("sat_done", sat_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
